// File: rtl/seg7_pkg.sv
// Shared constants, types and helpers for the 7-segment scan decoder.
// Glyph codes are active-high segment vectors ordered g..a.
package seg7_pkg;

  localparam int NUM_DIGITS = 8;

  localparam logic [6:0] SEG_0     = 7'h3F;
  localparam logic [6:0] SEG_1     = 7'h06;
  localparam logic [6:0] SEG_2     = 7'h5B;
  localparam logic [6:0] SEG_3     = 7'h4F;
  localparam logic [6:0] SEG_4     = 7'h66;
  localparam logic [6:0] SEG_5     = 7'h6D;
  localparam logic [6:0] SEG_6     = 7'h7D;
  localparam logic [6:0] SEG_7     = 7'h07;
  localparam logic [6:0] SEG_8     = 7'h7F;
  localparam logic [6:0] SEG_9     = 7'h6F;
  localparam logic [6:0] SEG_A     = 7'h77;
  localparam logic [6:0] SEG_B     = 7'h7C;
  localparam logic [6:0] SEG_C     = 7'h39;
  localparam logic [6:0] SEG_D     = 7'h5E;
  localparam logic [6:0] SEG_E     = 7'h79;
  localparam logic [6:0] SEG_F     = 7'h71;
  localparam logic [6:0] SEG_BLANK = 7'h00;

  typedef enum logic [1:0] {
    IDLE,
    SETTLE,
    CAPTURED
  } state_t;

  // Registered view of the pins: anodes, raw DP, active-high segments.
  typedef struct packed {
    logic [NUM_DIGITS-1:0] an;
    logic                  dp_n;
    logic [6:0]            seg;
  } in_t;

  // True when exactly one anode is driven low.
  function automatic logic an_selectable(input logic [NUM_DIGITS-1:0] an);
    return $countones(~an) == 1;
  endfunction

  // Index of the lowest low anode; meaningful only when an_selectable().
  function automatic logic [2:0] an_index(input logic [NUM_DIGITS-1:0] an);
    logic [2:0] idx;
    idx = '0;
    for (int i = NUM_DIGITS - 1; i >= 0; i--) begin
      if (!an[i]) idx = 3'(i);
    end
    return idx;
  endfunction

endpackage

// File: rtl/seg7_scan_decoder_if.sv
// Scanned display bus plus the reconstructed display state.
// The display driver (or bench) is the master; the decoder is the slave.
interface seg7_scan_decoder_if;
  import seg7_pkg::*;

  logic                    CA, CB, CC, CD, CE, CF, CG;
  logic                    DP;
  logic [NUM_DIGITS-1:0]   AN;
  logic [4*NUM_DIGITS-1:0] value;
  logic [NUM_DIGITS-1:0]   dp_mask;
  logic [NUM_DIGITS-1:0]   digit_valid;
  logic                    frame_valid;
  logic                    seg_err;

  modport master (
    output CA, CB, CC, CD, CE, CF, CG, DP, AN,
    input  value, dp_mask, digit_valid, frame_valid, seg_err
  );

  modport slave (
    input  CA, CB, CC, CD, CE, CF, CG, DP, AN,
    output value, dp_mask, digit_valid, frame_valid, seg_err
  );
endinterface

// File: rtl/seg7_glyph_decode.sv
// Combinational lookup from an active-high segment vector to a hex nibble.
// Blank is reported separately and is never legal.
module seg7_glyph_decode
  import seg7_pkg::*;
(
  input  logic [6:0] seg,
  output logic [3:0] nibble,
  output logic       legal,
  output logic       blank
);

  // NOTE: every output gets a default before the case so no latch is inferred.
  always_comb begin
    nibble = 4'h0;
    legal  = 1'b1;
    blank  = (seg == SEG_BLANK);
    case (seg)
      SEG_0:   nibble = 4'h0;
      SEG_1:   nibble = 4'h1;
      SEG_2:   nibble = 4'h2;
      SEG_3:   nibble = 4'h3;
      SEG_4:   nibble = 4'h4;
      SEG_5:   nibble = 4'h5;
      SEG_6:   nibble = 4'h6;
      SEG_7:   nibble = 4'h7;
      SEG_8:   nibble = 4'h8;
      SEG_9:   nibble = 4'h9;
      SEG_A:   nibble = 4'hA;
      SEG_B:   nibble = 4'hB;
      SEG_C:   nibble = 4'hC;
      SEG_D:   nibble = 4'hD;
      SEG_E:   nibble = 4'hE;
      SEG_F:   nibble = 4'hF;
      default: legal  = 1'b0;
    endcase
  end

endmodule

// File: rtl/seg7_scan_decoder.sv
// Watches a multiplexed 7-segment bus and rebuilds the displayed hex word,
// DP mask and per-digit validity once each digit has been stable long enough.
module seg7_scan_decoder
  import seg7_pkg::*;
#(
  parameter int SETTLE_CYCLES  = 4,
  parameter int TIMEOUT_CYCLES = 1_000_000
) (
  input  logic                CLK100MHZ,
  input  logic                CPU_RESETN,
  seg7_scan_decoder_if.slave  bus
);

  localparam int IDLE_W = (TIMEOUT_CYCLES > 2) ? $clog2(TIMEOUT_CYCLES) : 1;

  in_t                     w_pins;
  logic                    w_changed;
  logic                    w_capture;
  state_t                  r_state, w_state_next;
  logic [7:0]              r_cnt, w_cnt_next;

  in_t                     r_in;
  logic [IDLE_W-1:0]       r_idle_cnt;
  logic [NUM_DIGITS-1:0]   r_seen;
  logic [4*NUM_DIGITS-1:0] r_value;
  logic [NUM_DIGITS-1:0]   r_dp_mask;
  logic [NUM_DIGITS-1:0]   r_digit_valid;
  logic                    r_frame_valid;
  logic                    r_seg_err;

  logic [2:0]              w_idx;
  logic [NUM_DIGITS-1:0]   w_seen_next;
  logic [3:0]              w_nibble;
  logic                    w_legal;
  logic                    w_blank;

  assign w_pins    = {bus.AN, bus.DP, ~{bus.CG, bus.CF, bus.CE, bus.CD, bus.CC, bus.CB, bus.CA}};
  assign w_changed = (w_pins != r_in);

  // A capture always uses r_in, which equals the pins whenever one fires.
  assign w_idx       = an_index(r_in.an);
  assign w_seen_next = r_seen | (NUM_DIGITS'(1) << w_idx);

  seg7_glyph_decode u_glyph (
    .seg    (r_in.seg),
    .nibble (w_nibble),
    .legal  (w_legal),
    .blank  (w_blank)
  );

  // NOTE: sequential state uses non-blocking assignments so every register
  // samples pre-edge values regardless of statement order.
  always_ff @(posedge CLK100MHZ or negedge CPU_RESETN) begin
    if (!CPU_RESETN) begin
      r_state <= IDLE;
      r_cnt   <= '0;
    end else begin
      r_state <= w_state_next;
      r_cnt   <= w_cnt_next;
    end
  end

  always_comb begin
    w_state_next = r_state;
    w_cnt_next   = r_cnt;
    w_capture    = 1'b0;
    if (w_changed) begin
      w_cnt_next   = '0;
      w_state_next = an_selectable(w_pins.an) ? SETTLE : IDLE;
    end else begin
      case (r_state)
        SETTLE: begin
          if (r_cnt == 8'(SETTLE_CYCLES - 1)) begin
            w_capture    = 1'b1;
            w_state_next = CAPTURED;
          end else begin
            w_cnt_next = r_cnt + 8'd1;
          end
        end
        default: ;
      endcase
    end
  end

  // NOTE: the display state is a handful of flops, not a RAM, so every bit is
  // reset; a decoded word must never show stale data after reset.
  always_ff @(posedge CLK100MHZ or negedge CPU_RESETN) begin
    if (!CPU_RESETN) begin
      r_in          <= '1;
      r_idle_cnt    <= '0;
      r_seen        <= '0;
      r_value       <= '0;
      r_dp_mask     <= '0;
      r_digit_valid <= '0;
      r_frame_valid <= 1'b0;
      r_seg_err     <= 1'b0;
    end else begin
      r_in          <= w_pins;
      r_frame_valid <= 1'b0;
      r_seg_err     <= 1'b0;
      if (w_capture) begin
        r_idle_cnt <= '0;
        if (&w_seen_next) begin
          r_frame_valid <= 1'b1;
          r_seen        <= '0;
        end else begin
          r_seen <= w_seen_next;
        end
        if (w_legal) begin
          r_value[{w_idx, 2'b00} +: 4] <= w_nibble;
          r_digit_valid[w_idx]         <= 1'b1;
          r_dp_mask[w_idx]             <= ~r_in.dp_n;
        end else if (w_blank) begin
          r_digit_valid[w_idx] <= 1'b0;
          r_dp_mask[w_idx]     <= ~r_in.dp_n;
        end else begin
          r_digit_valid[w_idx] <= 1'b0;
          r_seg_err            <= 1'b1;
        end
      end else if (r_idle_cnt == IDLE_W'(TIMEOUT_CYCLES - 1)) begin
        // Display went dark for too long: validity drops, the last word holds.
        r_idle_cnt    <= '0;
        r_digit_valid <= '0;
        r_seen        <= '0;
      end else begin
        r_idle_cnt <= r_idle_cnt + 1'b1;
      end
    end
  end

  assign bus.value       = r_value;
  assign bus.dp_mask     = r_dp_mask;
  assign bus.digit_valid = r_digit_valid;
  assign bus.frame_valid = r_frame_valid;
  assign bus.seg_err     = r_seg_err;

endmodule

// File: tb/tb_seg7_scan_decoder.sv
// Bench for seg7_scan_decoder: directed scenarios then random scanning, all
// compared every cycle against a run-length based reference of the display.
module tb_seg7_scan_decoder;

  localparam int S = 4;
  localparam int T = 50;

  logic clk = 1'b0;
  logic rst_n;
  always #5 clk = ~clk;

  seg7_scan_decoder_if bus ();

  seg7_scan_decoder #(
    .SETTLE_CYCLES  (S),
    .TIMEOUT_CYCLES (T)
  ) dut (
    .CLK100MHZ  (clk),
    .CPU_RESETN (rst_n),
    .bus        (bus)
  );

  int checks = 0;
  int errors = 0;

  logic [6:0] glyphs [16] = '{7'h3F, 7'h06, 7'h5B, 7'h4F, 7'h66, 7'h6D, 7'h7D, 7'h07,
                              7'h7F, 7'h6F, 7'h77, 7'h7C, 7'h39, 7'h5E, 7'h79, 7'h71};

  // Reference: a digit is captured when the pins have been identical on the
  // last S+1 edges and not before; timeouts fall every T edges after a capture.
  logic [15:0] m_prev;
  int          m_run;
  int          m_edge;
  int          m_last;
  logic [31:0] m_value;
  logic [7:0]  m_dp, m_valid, m_seen;
  logic        m_frame, m_err;
  int          n_frame, n_err;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed %h expected %h", tag, obs, exp);
    end
  endtask

  task automatic model_reset();
    m_prev  = 16'hFFFF;
    m_run   = S + 1;
    m_last  = m_edge;
    m_value = '0;
    m_dp    = '0;
    m_valid = '0;
    m_seen  = '0;
    m_frame = 1'b0;
    m_err   = 1'b0;
  endtask

  task automatic model_edge(input logic [15:0] p);
    logic [7:0] an;
    logic [6:0] seg;
    int         idx, code;
    m_edge++;
    if (p != m_prev) m_run = 0;
    else if (m_run <= S) m_run++;
    m_prev  = p;
    m_frame = 1'b0;
    m_err   = 1'b0;
    an  = p[15:8];
    seg = p[6:0];
    if (m_run == S && $countones(~an) == 1) begin
      idx = 0;
      for (int i = 7; i >= 0; i--) if (!an[i]) idx = i;
      code = -1;
      for (int g = 0; g < 16; g++) if (glyphs[g] == seg) code = g;
      if (code >= 0) begin
        m_value[idx*4 +: 4] = 4'(code);
        m_valid[idx] = 1'b1;
        m_dp[idx]    = ~p[7];
      end else if (seg == 7'h00) begin
        m_valid[idx] = 1'b0;
        m_dp[idx]    = ~p[7];
      end else begin
        m_valid[idx] = 1'b0;
        m_err        = 1'b1;
      end
      m_seen[idx] = 1'b1;
      if (m_seen == 8'hFF) begin
        m_frame = 1'b1;
        m_seen  = '0;
      end
      m_last = m_edge;
    end else if ((m_edge - m_last) % T == 0) begin
      m_valid = '0;
      m_seen  = '0;
    end
  endtask

  task automatic drive(input logic [7:0] an, input logic dp_lit, input logic [6:0] seg);
    bus.AN = an;
    bus.DP = ~dp_lit;
    {bus.CG, bus.CF, bus.CE, bus.CD, bus.CC, bus.CB, bus.CA} = ~seg;
  endtask

  task automatic tick();
    logic [15:0] p;
    p = {bus.AN, bus.DP, ~{bus.CG, bus.CF, bus.CE, bus.CD, bus.CC, bus.CB, bus.CA}};
    @(posedge clk);
    model_edge(p);
    #1;
    check("value",       bus.value,       m_value);
    check("dp_mask",     32'(bus.dp_mask),     32'(m_dp));
    check("digit_valid", 32'(bus.digit_valid), 32'(m_valid));
    check("frame_valid", 32'(bus.frame_valid), 32'(m_frame));
    check("seg_err",     32'(bus.seg_err),     32'(m_err));
    n_frame += int'(bus.frame_valid);
    n_err   += int'(bus.seg_err);
  endtask

  task automatic hold(input logic [7:0] an, input logic dp_lit, input logic [6:0] seg, input int cycles);
    drive(an, dp_lit, seg);
    for (int i = 0; i < cycles; i++) tick();
  endtask

  task automatic check_all_zero(input string tag);
    check({tag, "_value"}, bus.value, 32'h0);
    check({tag, "_flags"}, {bus.dp_mask, bus.digit_valid, 6'd0, bus.frame_valid, bus.seg_err}, 32'h0);
  endtask

  initial begin
    logic [7:0] an;
    logic [6:0] seg;
    int         sel, len;

    m_edge = 0;
    rst_n  = 1'b0;
    drive(8'hFF, 1'b0, 7'h00);
    model_reset();
    #1;
    check_all_zero("reset");
    repeat (2) @(posedge clk);
    #1 rst_n = 1'b1;
    model_reset();

    // Single digit: capture exactly after edge E4.
    drive(8'hFE, 1'b0, 7'h3F);
    for (int i = 0; i < 10; i++) begin
      tick();
      if (i == S - 1) check("pre_capture_valid", 32'(bus.digit_valid), 32'h00);
      if (i == S)     check("first_capture_valid", 32'(bus.digit_valid), 32'h01);
    end
    check("first_frame_count", n_frame, 0);

    // Full scan of 1..8 with DP lit on digit 3.
    n_frame = 0;
    for (int d = 0; d < 8; d++) hold(~(8'h01 << d), d == 3, glyphs[d+1], 6);
    check("scan_frames", n_frame, 1);
    check("scan_value", bus.value, 32'h87654321);
    check("scan_dp", 32'(bus.dp_mask), 32'h08);
    check("scan_valid", 32'(bus.digit_valid), 32'hFF);

    // Glitching segments never settle; final stable glyph does.
    for (int k = 0; k < 4; k++) hold(8'hFD, 1'b0, k[0] ? 7'h07 : 7'h06, 3);
    check("toggle_no_capture", bus.value[7:4], 32'h2);
    check("toggle_valid_held", 32'(bus.digit_valid), 32'hFF);
    hold(8'hFD, 1'b0, 7'h07, 6);
    check("toggle_settled", bus.value[7:4], 32'h7);

    // Illegal glyph, then an ambiguous anode pattern.
    n_err = 0;
    hold(8'hFB, 1'b0, 7'h55, 6);
    check("illegal_err_count", n_err, 1);
    check("illegal_valid", 32'(bus.digit_valid), 32'hFB);
    hold(8'hF3, 1'b0, 7'h3F, 8);
    check("multi_an_no_capture", 32'(bus.digit_valid), 32'hFB);
    check("multi_an_err_count", n_err, 1);

    // Timeout T edges after the last capture.
    hold(8'hEF, 1'b0, 7'h7C, S + 1);
    drive(8'hFF, 1'b0, 7'h00);
    for (int i = 1; i <= T; i++) begin
      tick();
      if (i == T - 1) check("pre_timeout_valid", 32'(bus.digit_valid), 32'hFB);
    end
    check("timeout_valid", 32'(bus.digit_valid), 32'h00);
    check("timeout_value", bus.value, 32'h876B4371);

    // Reset in the middle of a settle window.
    hold(8'hDF, 1'b0, 7'h6D, 3);
    rst_n = 1'b0;
    #1;
    check_all_zero("mid_reset");
    model_reset();
    @(posedge clk);
    #1 rst_n = 1'b1;
    model_reset();
    for (int i = 0; i <= S; i++) begin
      tick();
      if (i == S - 1) check("post_reset_pre", 32'(bus.digit_valid), 32'h00);
    end
    check("post_reset_capture", 32'(bus.digit_valid), 32'h20);
    check("post_reset_value", bus.value, 32'h00500000);

    // Random scanning against the reference.
    for (int r = 0; r < 250; r++) begin
      sel = int'($urandom_range(0, 9));
      if (sel <= 6)      seg = glyphs[$urandom_range(0, 15)];
      else if (sel == 7) seg = 7'h00;
      else               seg = 7'($urandom);
      sel = int'($urandom_range(0, 9));
      if (sel <= 7)      an = ~(8'h01 << $urandom_range(0, 7));
      else if (sel == 8) an = 8'($urandom);
      else               an = 8'hFF;
      len = (sel == 9 && $urandom_range(0, 3) == 0) ? T + 5 : int'($urandom_range(1, 8));
      hold(an, 1'($urandom), seg, len);
    end

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
